simd_seq_ctrl: RTL and testbench

Program sequencer for the SIMD datapath. It owns the program counter and the `stall` input of the datapath, and it starts execution on a host request. It steps the PC once per datapath half-clock phase, detects the HALT opcode, and drains the three-stage pipeline (load, exec, store) before reporting completion. It sits between the host/AXI-lite register block and the datapath/instruction BRAM.

---
 rtl/simd_seq_if.sv | 38 +++
 rtl/simd_seq_ctrl.sv | 145 ++++++++++++++
 tb/tb_simd_seq_ctrl.sv | 432 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/simd_seq_if.sv
// Host/datapath handshake bundle for the SIMD program sequencer.
// SIMD_SEQ_PERF_CNT_EN adds the run_cycles performance counter signal.
interface simd_seq_if #(
    parameter int unsigned INS_ADDR_WIDTH = 8,
    parameter int unsigned OPCODE_WIDTH   = 4
);
    logic                      half_clk;
    logic                      start;
    logic [INS_ADDR_WIDTH-1:0] start_pc;
    logic                      abort;
    logic                      pause;
    logic [OPCODE_WIDTH-1:0]   ins_opcode;
    logic [INS_ADDR_WIDTH-1:0] pc;
    logic                      stall;
    logic                      busy;
    logic                      done;
    logic                      aborted;
    logic [INS_ADDR_WIDTH:0]   ins_count;
`ifdef SIMD_SEQ_PERF_CNT_EN
    logic [31:0]               run_cycles;
`endif

    modport master (
        output half_clk, start, start_pc, abort, pause, ins_opcode,
        input  pc, stall, busy, done, aborted, ins_count
`ifdef SIMD_SEQ_PERF_CNT_EN
        , input run_cycles
`endif
    );

    modport slave (
        input  half_clk, start, start_pc, abort, pause, ins_opcode,
        output pc, stall, busy, done, aborted, ins_count
`ifdef SIMD_SEQ_PERF_CNT_EN
        , output run_cycles
`endif
    );
endinterface

// File: rtl/simd_seq_ctrl.sv
// Program sequencer: owns the PC and datapath stall, detects HALT and drains the pipeline.
// Optional SIMD_SEQ_PERF_CNT_EN builds a saturating busy-cycle counter (run_cycles).
//
// state   | meaning
// IDLE    | waiting for start, datapath stalled
// FETCH   | first PC loaded, waiting one step for BRAM data
// RUN     | issuing one instruction per unpaused step
// DRAIN   | HALT seen, flushing load/exec/store stages
// DONE    | one-clk completion pulse
module simd_seq_ctrl #(
    parameter int unsigned             INS_ADDR_WIDTH = 8,
    parameter int unsigned             OPCODE_WIDTH   = 4,
    parameter logic [OPCODE_WIDTH-1:0] HALT_OPCODE    = 4'hF,
    parameter int unsigned             DRAIN_STEPS    = 3
) (
    input  logic      clk,
    input  logic      rstn,
    simd_seq_if.slave bus
);
    localparam int unsigned CNT_W   = INS_ADDR_WIDTH + 1;
    localparam int unsigned DRAIN_W = (DRAIN_STEPS < 2) ? 1 : $clog2(DRAIN_STEPS + 1);
    localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(DRAIN_STEPS);

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t                    state_q, state_d;
    logic [INS_ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [CNT_W-1:0]          ins_count_q, ins_count_d;
    logic [DRAIN_W-1:0]        drain_q, drain_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;
    logic                      aborted_q, aborted_d;
    logic                      step;

    assign step = bus.half_clk && !bus.pause;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ins_count_d = ins_count_q;
        drain_d     = drain_q;
        aborted_d   = aborted_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d     = S_FETCH;
                    pc_d        = bus.start_pc;
                    ins_count_d = '0;
                    aborted_d   = 1'b0;
                end
            end
            S_FETCH: begin
                if (bus.abort) begin
                    state_d   = S_DONE;
                    aborted_d = 1'b1;
                end else if (step) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                // abort takes priority over a HALT seen on the same edge
                if (bus.abort) begin
                    state_d   = S_DONE;
                    aborted_d = 1'b1;
                end else if (step) begin
                    if (bus.ins_opcode == HALT_OPCODE) begin
                        state_d = S_DRAIN;
                        drain_d = DRAIN_LOAD;
                    end else begin
                        pc_d = pc_q + 1'b1;
                        if (ins_count_q != '1) begin
                            ins_count_d = ins_count_q + 1'b1;
                        end
                    end
                end
            end
            S_DRAIN: begin
                if (bus.abort) begin
                    state_d   = S_DONE;
                    aborted_d = 1'b1;
                end else if (!bus.pause) begin
                    if (drain_q == '0) begin
                        state_d = S_DONE;
                    end else if (bus.half_clk) begin
                        drain_d = drain_q - 1'b1;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

`ifdef SIMD_SEQ_PERF_CNT_EN
    logic [31:0] run_cycles_q, run_cycles_d;

    always_comb begin
        run_cycles_d = run_cycles_q;
        if (state_q == S_IDLE && bus.start) begin
            run_cycles_d = '0;
        end else if (busy_q && run_cycles_q != '1) begin
            run_cycles_d = run_cycles_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            run_cycles_q <= '0;
        end else begin
            run_cycles_q <= run_cycles_d;
        end
    end

    assign bus.run_cycles = run_cycles_q;
`endif

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= S_IDLE;
            pc_q        <= '0;
            ins_count_q <= '0;
            drain_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            aborted_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            ins_count_q <= ins_count_d;
            drain_q     <= drain_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            aborted_q   <= aborted_d;
        end
    end

    assign bus.stall     = (state_q == S_RUN || state_q == S_DRAIN) ? bus.pause : 1'b1;
    assign bus.pc        = pc_q;
    assign bus.ins_count = ins_count_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.aborted   = aborted_q;
endmodule

// File: tb/tb_simd_seq_ctrl.sv
// Self-checking bench for simd_seq_ctrl: BRAM model, done scoreboard and per-scenario tasks.
module tb_simd_seq_ctrl;
    typedef struct packed {
        logic [8:0] cnt;
        logic [7:0] pc;
        logic       ab;
    } exp_t;

    logic       clk  = 1'b0;
    logic       rstn = 1'b0;
    logic [3:0] mem [0:255];
    exp_t       exp_q [$];
    logic [7:0] pc_trace [$];
    logic [7:0] prev_pc = 8'h00;
    int         errors = 0;
    int         checks = 0;
    int         cyc    = 0;

    simd_seq_if #(.INS_ADDR_WIDTH(8), .OPCODE_WIDTH(4)) bus ();

    simd_seq_ctrl #(
        .INS_ADDR_WIDTH(8),
        .OPCODE_WIDTH  (4),
        .HALT_OPCODE   (4'hF),
        .DRAIN_STEPS   (3)
    ) dut (
        .clk (clk),
        .rstn(rstn),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    // half_clk alternates every clk; BRAM returns mem[pc] shortly after each edge
    initial begin
        bus.half_clk   = 1'b0;
        bus.ins_opcode = 4'h0;
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
            #1 bus.ins_opcode = mem[bus.pc];
            #1 bus.half_clk = ~bus.half_clk;
        end
    end

    // done scoreboard and PC trace
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rstn && bus.pc !== prev_pc) pc_trace.push_back(bus.pc);
            prev_pc = bus.pc;
            if (bus.done === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL done_unexpected: done seen with no run outstanding");
                end else begin
                    e = exp_q.pop_front();
                    if (bus.ins_count !== e.cnt || bus.pc !== e.pc || bus.aborted !== e.ab) begin
                        errors++;
                        $display("FAIL done_result: got cnt=%0d pc=%h ab=%0d, want cnt=%0d pc=%h ab=%0d",
                                 bus.ins_count, bus.pc, bus.aborted, e.cnt, e.pc, e.ab);
                    end
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_pc(input logic [7:0] target, input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            tick();
            if (bus.pc === target) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_done(input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            tick();
            if (bus.done === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic launch(input logic [7:0] spc);
        pc_trace.delete();
        bus.start_pc = spc;
        bus.start    = 1'b1;
        tick();
        bus.start    = 1'b0;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        tick();
        tick();
        checks++;
        if (bus.pc !== 8'h00 || bus.stall !== 1'b1 || bus.busy !== 1'b0 || bus.done !== 1'b0 ||
            bus.aborted !== 1'b0 || bus.ins_count !== 9'd0) begin
            errors++;
            $display("FAIL reset_values: pc=%h stall=%0d busy=%0d done=%0d ab=%0d cnt=%0d, want 0/1/0/0/0/0",
                     bus.pc, bus.stall, bus.busy, bus.done, bus.aborted, bus.ins_count);
        end
        rstn = 1'b1;
        tick();
        checks++;
        if (bus.busy !== 1'b0 || bus.stall !== 1'b1) begin
            errors++;
            $display("FAIL idle_after_reset: busy=%0d stall=%0d, want 0/1", bus.busy, bus.stall);
        end
    endtask

    task automatic test_basic();
        bit ok;
        int t_halt_pc, t_done;
        for (int i = 0; i < 5; i++) mem[8'h10 + i] = 4'(i + 1);
        mem[8'h15] = 4'hF;
        exp_q.push_back({9'd5, 8'h15, 1'b0});
        launch(8'h10);
        checks++;
        if (bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL basic_accept: busy=%0d want 1", bus.busy);
        end
        wait_pc(8'h15, 40, ok);
        t_halt_pc = cyc;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL basic_reach_halt: pc=%h want 15", bus.pc);
        end
        // HALT is sampled on the step edge two clk after pc reaches it
        wait_done(40, ok);
        t_done = cyc;
        checks++;
        if (!ok || (t_done - t_halt_pc) != 9) begin
            errors++;
            $display("FAIL basic_halt_latency: done after %0d clk (seen=%0d), want 7 after HALT sample",
                     t_done - t_halt_pc - 2, ok);
        end
        tick();
        checks++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_done_pulse: done=%0d busy=%0d, want 0/0", bus.done, bus.busy);
        end
        checks++;
        if (pc_trace.size() != 6) begin
            errors++;
            $display("FAIL basic_trace_len: %0d want 6", pc_trace.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                if (pc_trace[i] !== 8'(8'h10 + i)) begin
                    errors++;
                    $display("FAIL basic_trace: idx %0d got %h want %h", i, pc_trace[i], 8'(8'h10 + i));
                end
            end
        end
    endtask

    task automatic test_wrap();
        bit ok;
        logic [7:0] want [4];
        want[0] = 8'hFE; want[1] = 8'hFF; want[2] = 8'h00; want[3] = 8'h01;
        mem[8'hFE] = 4'h1; mem[8'hFF] = 4'h2; mem[8'h00] = 4'h3; mem[8'h01] = 4'hF;
        exp_q.push_back({9'd3, 8'h01, 1'b0});
        launch(8'hFE);
        wait_done(60, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL wrap_done: no done within bound");
        end
        checks++;
        if (pc_trace.size() != 4) begin
            errors++;
            $display("FAIL wrap_trace_len: %0d want 4", pc_trace.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (pc_trace[i] !== want[i]) begin
                    errors++;
                    $display("FAIL wrap_trace: idx %0d got %h want %h", i, pc_trace[i], want[i]);
                end
            end
        end
        tick();
    endtask

    task automatic test_pause();
        bit ok;
        for (int i = 0; i < 8; i++) mem[8'h30 + i] = 4'h2;
        mem[8'h38] = 4'hF;
        exp_q.push_back({9'd8, 8'h38, 1'b0});
        launch(8'h30);
        wait_pc(8'h33, 40, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL pause_reach: pc=%h want 33", bus.pc);
        end
        bus.pause = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            checks++;
            if (bus.stall !== 1'b1 || bus.pc !== 8'h33) begin
                errors++;
                $display("FAIL pause_hold: cycle %0d stall=%0d pc=%h, want 1/33", i, bus.stall, bus.pc);
            end
            tick();
        end
        checks++;
        if (bus.pc !== 8'h33) begin
            errors++;
            $display("FAIL pause_frozen_end: pc=%h want 33", bus.pc);
        end
        bus.pause = 1'b0;
        #1;
        checks++;
        if (bus.stall !== 1'b0) begin
            errors++;
            $display("FAIL pause_release_stall: stall=%0d want 0", bus.stall);
        end
        wait_done(60, ok);
        checks++;
        if (!ok || pc_trace.size() != 9) begin
            errors++;
            $display("FAIL pause_trace_len: %0d (done=%0d) want 9", pc_trace.size(), ok);
        end else begin
            for (int i = 0; i < 9; i++) begin
                if (pc_trace[i] !== 8'(8'h30 + i)) begin
                    errors++;
                    $display("FAIL pause_trace: idx %0d got %h want %h", i, pc_trace[i], 8'(8'h30 + i));
                end
            end
        end
        tick();
    endtask

    task automatic test_abort();
        bit ok;
        mem[8'h40] = 4'h1;
        mem[8'h41] = 4'hF;
        exp_q.push_back({9'd1, 8'h41, 1'b1});
        launch(8'h40);
        wait_pc(8'h41, 40, ok);
        repeat (4) tick();
        checks++;
        if (!ok || bus.busy !== 1'b1 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL abort_in_drain: reached=%0d busy=%0d done=%0d, want 1/1/0", ok, bus.busy, bus.done);
        end
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        checks++;
        if (bus.done !== 1'b1 || bus.aborted !== 1'b1 || bus.stall !== 1'b1) begin
            errors++;
            $display("FAIL abort_response: done=%0d ab=%0d stall=%0d, want 1/1/1", bus.done, bus.aborted, bus.stall);
        end
        tick();
        checks++;
        if (bus.busy !== 1'b0 || bus.aborted !== 1'b1) begin
            errors++;
            $display("FAIL abort_sticky: busy=%0d ab=%0d, want 0/1", bus.busy, bus.aborted);
        end
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL abort_idle_ignored: busy=%0d done=%0d, want 0/0", bus.busy, bus.done);
        end
        exp_q.push_back({9'd0, 8'h41, 1'b0});
        launch(8'h41);
        checks++;
        if (bus.aborted !== 1'b0 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL abort_clear_on_start: ab=%0d busy=%0d, want 0/1", bus.aborted, bus.busy);
        end
        wait_done(40, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL halt_first_done: no done within bound");
        end
        tick();
    endtask

    task automatic test_reset_mid_run();
        bit ok;
        for (int i = 0; i < 20; i++) mem[8'h1C + i] = 4'h4;
        launch(8'h1C);
        wait_pc(8'h20, 40, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL rst_reach: pc=%h want 20", bus.pc);
        end
        rstn      = 1'b0;
        bus.start = 1'b1;
        bus.start_pc = 8'h41;
        tick();
        checks++;
        if (bus.pc !== 8'h00 || bus.stall !== 1'b1 || bus.busy !== 1'b0 || bus.done !== 1'b0 ||
            bus.aborted !== 1'b0 || bus.ins_count !== 9'd0) begin
            errors++;
            $display("FAIL rst_mid_run: pc=%h stall=%0d busy=%0d done=%0d ab=%0d cnt=%0d, want 0/1/0/0/0/0",
                     bus.pc, bus.stall, bus.busy, bus.done, bus.aborted, bus.ins_count);
        end
        repeat (3) tick();
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_start_ignored: busy=%0d want 0", bus.busy);
        end
        exp_q.push_back({9'd0, 8'h41, 1'b0});
        rstn = 1'b1;
        tick();
        bus.start = 1'b0;
        checks++;
        if (bus.busy !== 1'b1 || bus.pc !== 8'h41) begin
            errors++;
            $display("FAIL rst_release_start: busy=%0d pc=%h, want 1/41", bus.busy, bus.pc);
        end
        wait_done(40, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL rst_restart_done: no done within bound");
        end
        tick();
    endtask

    task automatic test_back_to_back();
        bit ok;
        mem[8'h60] = 4'h1;
        mem[8'h61] = 4'hF;
        exp_q.push_back({9'd1, 8'h61, 1'b0});
        exp_q.push_back({9'd1, 8'h61, 1'b0});
        bus.start_pc = 8'h60;
        bus.start    = 1'b1;
        tick();
        wait_done(40, ok);
        checks++;
        if (!ok || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_first_done: done=%0d busy=%0d, want 1/1", ok, bus.busy);
        end
        tick();
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle_gap: busy=%0d done=%0d, want 0/0", bus.busy, bus.done);
        end
        tick();
        checks++;
        if (bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_restart: busy=%0d want 1", bus.busy);
        end
`ifdef SIMD_SEQ_PERF_CNT_EN
        checks++;
        if (bus.run_cycles !== 32'd0) begin
            errors++;
            $display("FAIL b2b_perf_clear: run_cycles=%0d want 0", bus.run_cycles);
        end
`endif
        tick();
        bus.start = 1'b0;
`ifdef SIMD_SEQ_PERF_CNT_EN
        checks++;
        if (bus.run_cycles !== 32'd1) begin
            errors++;
            $display("FAIL b2b_perf_count: run_cycles=%0d want 1", bus.run_cycles);
        end
`endif
        wait_done(40, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL b2b_second_done: no done within bound");
        end
        tick();
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL b2b_final_idle: busy=%0d done=%0d, want 0/0", bus.busy, bus.done);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 4'h1;
        bus.start    = 1'b0;
        bus.start_pc = 8'h00;
        bus.abort    = 1'b0;
        bus.pause    = 1'b0;
        test_reset();
        test_basic();
        test_wrap();
        test_pause();
        test_abort();
        test_reset_mid_run();
        test_back_to_back();
        repeat (3) tick();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d runs without done, want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
